// File: rtl/klp_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject requests before touching memory.
package klp_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_MRG  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // size 2'b11 is not a legal access and is reported like a misalignment
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/klp_lsu_lane.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into a previously read word.
module klp_lsu_lane
    import klp_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;

    // halfword accesses are aligned here, so a byte-granular shift also serves them
    assign shifted = word_i >> {addr_lo_i, 3'b000};

    always_comb begin
        case (size_i)
            SZ_B:    load_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: load_o = word_i;
        endcase
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        logic       sel;
        logic [7:0] src;

        always_comb begin
            sel = 1'b1;
            src = wdata_i[8*gi +: 8];
            case (size_i)
                SZ_B: begin
                    sel = (addr_lo_i == 2'(gi % 4));
                    src = wdata_i[7:0];
                end
                SZ_H: begin
                    sel = (addr_lo_i[1] == 1'((gi / 2) % 2));
                    src = wdata_i[8*(gi % 2) +: 8];
                end
                default: ;
            endcase
        end

        assign merge_o[8*gi +: 8] = sel ? src : word_i[8*gi +: 8];
    end

endmodule

// File: rtl/klp_lsu.sv
// Load/store unit: drives a single-port word memory, performing byte/half
// accesses by extraction on load and read-modify-write on store.
module klp_lsu
    import klp_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    logic [2:0]      state_q,    state_d;
    logic            write_q,    write_d;
    logic [1:0]      size_q,     size_d;
    logic            uns_q,      uns_d;
    logic [1:0]      lo_q,       lo_d;
    logic [XLEN-1:0] wdata_q,    wdata_d;
    logic [AW-1:0]   maddr_q,    maddr_d;
    logic [XLEN-1:0] mwdata_q,   mwdata_d;
    logic [XLEN-1:0] rdata_q,    rdata_d;
    logic            err_q,      err_d;

    logic [XLEN-1:0] lane_load;
    logic [XLEN-1:0] lane_merge;

    klp_lsu_lane #(.XLEN(XLEN)) u_lane (
        .word_i     (mem_read_data),
        .wdata_i    (wdata_q),
        .addr_lo_i  (lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        uns_d    = uns_q;
        lo_d     = lo_q;
        wdata_d  = wdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lo_d    = req_addr[1:0];
                    wdata_d = req_wdata;
                    maddr_d = AW'(req_addr[XLEN-1:2]);
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_write && req_size == SZ_W) begin
                        mwdata_d = req_wdata;
                        state_d  = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_MRG;
            ST_MRG: begin
                if (write_q) begin
                    mwdata_d = lane_merge;
                    state_d  = ST_WR;
                end else begin
                    rdata_d = lane_load;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            lo_q     <= 2'b00;
            wdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            lo_q     <= lo_d;
            wdata_q  <= wdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP);
    assign mem_write_enable = (state_q == ST_WR);
    assign mem_addr         = maddr_q;
    assign mem_write_data   = mwdata_q;
    assign resp_rdata       = rdata_q;
    assign resp_error       = err_q;

endmodule
